// File: rtl/regfile_writeback_queue.sv
// Writeback queue for the register-file write port, doubling as a pending-write scoreboard for decode.
// Define WB_BYPASS_EN to build youngest-entry forwarding on fwd_data1/2 (tied to 0 otherwise).
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     drain_en,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     reg_write,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        query_reg1,
  input  logic [ADDR_W-1:0]        query_reg2,
  output logic                     pending1,
  output logic                     pending2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_acc_mem;
  logic              w_acc_alu;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_push_rd;
  logic [DATA_W-1:0] w_push_data;

  function automatic logic f_pending(
    input logic [ADDR_W-1:0] q,
    input logic [DEPTH-1:0]  vld,
    input logic [ADDR_W-1:0] rd [DEPTH]
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      hit = hit | (vld[k] & (rd[k] == q));
    end
    return hit & (q != '0);
  endfunction

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest from the head so the last match is the youngest entry.
  function automatic logic [DATA_W-1:0] f_youngest(
    input logic [ADDR_W-1:0] q,
    input logic [PW-1:0]     head,
    input logic [DEPTH-1:0]  vld,
    input logic [ADDR_W-1:0] rd   [DEPTH],
    input logic [DATA_W-1:0] data [DEPTH]
  );
    logic [DATA_W-1:0] res;
    logic [PW-1:0]     idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (vld[idx] && (rd[idx] == q) && (q != '0)) begin
        res = data[idx];
      end
    end
    return res;
  endfunction
`endif

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign mem_ready = !w_full && !flush;
  assign alu_ready = !w_full && !flush && !mem_valid;
  assign w_acc_mem = mem_valid && mem_ready;
  assign w_acc_alu = alu_valid && alu_ready;

  assign w_push_rd   = w_acc_mem ? mem_rd   : alu_rd;
  assign w_push_data = w_acc_mem ? mem_data : alu_data;
  // x0 results complete the handshake but never occupy a slot.
  assign w_push      = (w_acc_mem || w_acc_alu) && (w_push_rd != '0);

  assign reg_write  = !w_empty && drain_en && !flush;
  assign w_pop      = reg_write;
  assign write_reg  = w_empty ? '0 : r_rd[r_rd_ptr];
  assign write_data = w_empty ? '0 : r_data[r_rd_ptr];
  assign count      = r_count;

  assign pending1 = f_pending(query_reg1, r_vld, r_rd);
  assign pending2 = f_pending(query_reg2, r_vld, r_rd);

`ifdef WB_BYPASS_EN
  assign fwd_data1 = f_youngest(query_reg1, r_rd_ptr, r_vld, r_rd, r_data);
  assign fwd_data2 = f_youngest(query_reg2, r_rd_ptr, r_vld, r_rd, r_data);
`else
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

  // Queue storage, pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_rd[r_wr_ptr]   <= w_push_rd;
        r_data[r_wr_ptr] <= w_push_data;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
